seven_segment_scan_driver: RTL

Parametrised multiplexed seven-segment display driver for the 7-segment LED expansion module and wider boards. It takes a hex word, per-digit decimal points and blanking, and a brightness level. Its scan engine enables one digit at a time. Updates are double-buffered and applied only at frame boundaries so no digit tears. It adds full hex decode, leading-zero blanking, PWM dimming, anti-ghost dead time and selectable drive polarity.

---
 rtl/seven_segment_scan_driver.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_driver
// Brief    : Multiplexed seven-segment display driver with a double-buffered
//            frame, full hex decode, leading-zero blanking, PWM dimming,
//            anti-ghost dead time and selectable drive polarity.
//
// Ports
//   clk            in   1             system clock
//   rst_n          in   1             asynchronous active-low reset
//   load           in   1             strobe: capture digits/dp/blank/brightness
//                                     into the shadow registers
//   digits         in   4*NUM_DIGITS  hex nibbles, digit 0 (rightmost) = [3:0]
//   dp             in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank          in   NUM_DIGITS    forced blank per digit (dp included)
//   brightness     in   PWM_BITS      on-duty level, 0 = dark
//   sevensegment   out  8             segments abcdefgh (bit7 = a, bit0 = dp)
//   enable         out  NUM_DIGITS    digit enables
//   update_pending out  1             shadow holds data not yet committed
//   frame_done     out  1             one-cycle pulse per frame boundary
//
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 25000,
    parameter int DEAD_CYCLES = 4,
    parameter int PWM_BITS    = 4,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [7:0]              sevensegment,
    output logic [NUM_DIGITS-1:0]   enable,
    output logic                    update_pending,
    output logic                    frame_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int C_I_W = $clog2(NUM_DIGITS);

    localparam logic [C_P_W-1:0] C_P_LAST = C_P_W'(SCAN_DIV - 1);
    localparam logic [C_P_W-1:0] C_P_DEAD = C_P_W'(DEAD_CYCLES);
    localparam logic [C_I_W-1:0] C_I_LAST = C_I_W'(NUM_DIGITS - 1);

    // The "all off" pin pattern doubles as the polarity XOR mask: an
    // active-high value XOR this mask gives the pin level.
    localparam logic [7:0]            C_SEG_OFF = {8{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] C_EN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (NUM_DIGITS < 2) begin : g_chk_digits
        $error("NUM_DIGITS must be >= 2");
    end
    if (SCAN_DIV <= DEAD_CYCLES) begin : g_chk_div
        $error("SCAN_DIV must be greater than DEAD_CYCLES");
    end
    if (PWM_BITS < 1) begin : g_chk_pwm
        $error("PWM_BITS must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Hex to segment decode, active-high abcdefg in bits [7:1], dp slot zero
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hFC;
            4'h1:    seg = 8'h60;
            4'h2:    seg = 8'hDA;
            4'h3:    seg = 8'hF2;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'hB6;
            4'h6:    seg = 8'hBE;
            4'h7:    seg = 8'hE0;
            4'h8:    seg = 8'hFE;
            4'h9:    seg = 8'hF6;
            4'hA:    seg = 8'hEE;
            4'hB:    seg = 8'h3E;
            4'hC:    seg = 8'h9C;
            4'hD:    seg = 8'h7A;
            4'hE:    seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Scan engine: prescaler p, digit index i, PWM counter q
    // ------------------------------------------------------------------------
    logic [C_P_W-1:0]    r_p;
    logic [C_I_W-1:0]    r_i;
    logic [PWM_BITS-1:0] r_q;

    logic w_slot_end;
    logic w_frame_end;

    assign w_slot_end  = (r_p == C_P_LAST);
    assign w_frame_end = w_slot_end && (r_i == C_I_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
            r_i <= '0;
            r_q <= '0;
        end else begin
            if (w_slot_end) begin
                r_p <= '0;
                // Explicit wrap so non-power-of-two digit counts work.
                r_i <= (r_i == C_I_LAST) ? '0 : r_i + C_I_W'(1);
            end else begin
                r_p <= r_p + C_P_W'(1);
            end
            // The PWM phase is re-aligned to every slot so each digit sees
            // the same duty pattern after its dead time.
            r_q <= w_slot_end ? '0 : r_q + PWM_BITS'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Double buffer: shadow written by load, active updated only at the
    // frame boundary so a frame never mixes old and new data.
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [PWM_BITS-1:0]     r_sh_bright;

    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [PWM_BITS-1:0]     r_act_bright;

    logic r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_sh_bright  <= '0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_act_bright <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp;
                r_sh_blank  <= blank;
                r_sh_bright <= brightness;
            end
            // Commit reads the pre-edge shadow; a load on the same edge
            // therefore lands in the next frame and keeps pending set.
            if (w_frame_end && r_pending) begin
                r_act_digits <= r_sh_digits;
                r_act_dp     <= r_sh_dp;
                r_act_blank  <= r_sh_blank;
                r_act_bright <= r_sh_bright;
            end
            r_pending <= load | (r_pending & ~w_frame_end);
        end
    end

    assign update_pending = r_pending;

    // ------------------------------------------------------------------------
    // Per-digit segment bytes (active-high), including blanking rules
    // ------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][7:0] w_digit_seg;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [3:0] w_nib;
        logic       w_lz;

        assign w_nib = r_act_digits[4*k +: 4];

        if (k == 0) begin : g_lsd
            // The rightmost digit always shows, so a value of zero reads "0".
            assign w_lz = 1'b0;
        end else begin : g_upper
            // Blank when this nibble and every nibble above it are zero.
            assign w_lz = LZ_BLANK && (r_act_digits[4*NUM_DIGITS-1:4*k] == '0);
        end

        // Forced blank wins over everything; leading-zero blanking keeps dp.
        assign w_digit_seg[k] = r_act_blank[k] ? 8'h00 :
                                w_lz           ? {7'b0, r_act_dp[k]} :
                                (f_decode(w_nib) | {7'b0, r_act_dp[k]});
    end

    // ------------------------------------------------------------------------
    // Lit decision and registered outputs
    // ------------------------------------------------------------------------
    logic                  w_lit;
    logic [7:0]            w_seg_ah;
    logic [NUM_DIGITS-1:0] w_en_ah;

    assign w_lit    = (r_p >= C_P_DEAD) && (r_q < r_act_bright);
    assign w_seg_ah = w_digit_seg[r_i];
    assign w_en_ah  = w_lit ? (NUM_DIGITS'(1) << r_i) : '0;

    // Segments and enables leave through the same register stage so they
    // switch on the same edge; the dead time then covers the changeover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sevensegment <= C_SEG_OFF;
            enable       <= C_EN_OFF;
            frame_done   <= 1'b0;
        end else begin
            sevensegment <= w_seg_ah ^ C_SEG_OFF;
            enable       <= w_en_ah ^ C_EN_OFF;
            frame_done   <= w_frame_end;
        end
    end

endmodule
`default_nettype wire
